regfile_wport_arbiter: RTL and testbench

// - Shares the single register-file write port (wen/waddr/wdata) between NREQ write requesters.
// - Requesters include the pipeline writeback stage, the multi-cycle multiply unit and the load unit.
// - Each requester uses a valid/ready handshake; the arbiter grants round-robin.
// - It sits between the requesters and regfile, and registers the winning write onto the port.

---
 rtl/regfile_wport_arbiter_if.sv | 29 ++
 rtl/regfile_wport_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wport_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of requester handshakes and the shared register-file write port.
// master = requester/regfile side, slave = arbiter side.
interface regfile_wport_arbiter_if #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 16,
    parameter int NREQ  = 3,
    parameter int IDW   = 3
);
    logic                   rf_hold;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ASIZE-1:0]  req_addr;
    logic [NREQ*DSIZE-1:0]  req_data;
    logic                   rf_wen;
    logic [ASIZE-1:0]       rf_waddr;
    logic [DSIZE-1:0]       rf_wdata;
    logic [IDW-1:0]         grant_id;
    logic                   busy;

    modport master (
        output rf_hold, req_valid, req_addr, req_data,
        input  req_ready, rf_wen, rf_waddr, rf_wdata, grant_id, busy
    );

    modport slave (
        input  rf_hold, req_valid, req_addr, req_data,
        output req_ready, rf_wen, rf_waddr, rf_wdata, grant_id, busy
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ requesters.
// Optional macro WARB_PRIO0_EN: requester 0 gets fixed top priority, others round-robin.
module regfile_wport_arbiter #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 16,
    parameter int NREQ  = 3,
    parameter int IDW   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_wport_arbiter_if.slave    bus
);

`ifdef WARB_PRIO0_EN
    localparam logic [IDW-1:0] RR_BASE = IDW'(1);
`else
    localparam logic [IDW-1:0] RR_BASE = '0;
`endif
    localparam logic [IDW-1:0] RR_LAST = IDW'(NREQ - 1);

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             rf_wen_q, rf_wen_d;
    logic [ASIZE-1:0] rf_waddr_q, rf_waddr_d;
    logic [DSIZE-1:0] rf_wdata_q, rf_wdata_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;

    logic [NREQ-1:0]  hi_mask;
    logic [NREQ-1:0]  lo_mask;
    logic [NREQ-1:0]  sel_mask;
    logic [NREQ-1:0]  win_onehot;
    logic [NREQ-1:0]  ready_c;
    logic             grant_any;

    logic [NREQ:0][IDW-1:0]   id_chain;
    logic [NREQ:0][ASIZE-1:0] addr_chain;
    logic [NREQ:0][DSIZE-1:0] data_chain;

    assign id_chain[0]   = '0;
    assign addr_chain[0] = '0;
    assign data_chain[0] = '0;

    // hi_mask keeps requesters at or above rr_ptr so the lowest set bit is the
    // first valid one in the circular scan; lo_mask covers the wrap-around.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign hi_mask[gi] = bus.req_valid[gi] & (IDW'(gi) >= rr_ptr_q);
            assign id_chain[gi+1]   = id_chain[gi] | (win_onehot[gi] ? IDW'(gi) : '0);
            assign addr_chain[gi+1] = addr_chain[gi]
                                    | (bus.req_addr[gi*ASIZE +: ASIZE] & {ASIZE{win_onehot[gi]}});
            assign data_chain[gi+1] = data_chain[gi]
                                    | (bus.req_data[gi*DSIZE +: DSIZE] & {DSIZE{win_onehot[gi]}});
        end
    endgenerate

`ifdef WARB_PRIO0_EN
    assign lo_mask = bus.req_valid & ~NREQ'(1);
`else
    assign lo_mask = bus.req_valid;
`endif

    always_comb begin
        sel_mask   = (|hi_mask) ? hi_mask : lo_mask;
        win_onehot = sel_mask & (~sel_mask + NREQ'(1));
`ifdef WARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            win_onehot = NREQ'(1);
        end
`endif
    end

    always_comb begin
        ready_c    = (rst || bus.rf_hold) ? '0 : win_onehot;
        grant_any  = |ready_c;
        rr_ptr_d   = rr_ptr_q;
        rf_wen_d   = grant_any;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        if (grant_any) begin
            rf_waddr_d = addr_chain[NREQ];
            rf_wdata_d = data_chain[NREQ];
            grant_id_d = id_chain[NREQ];
`ifdef WARB_PRIO0_EN
            // Grants to the priority requester leave the rotation untouched.
            if (id_chain[NREQ] != '0) begin
                rr_ptr_d = (id_chain[NREQ] == RR_LAST) ? RR_BASE : id_chain[NREQ] + IDW'(1);
            end
`else
            rr_ptr_d = (id_chain[NREQ] == RR_LAST) ? RR_BASE : id_chain[NREQ] + IDW'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= RR_BASE;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.busy      = |(bus.req_valid & ~ready_c);
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed-vector bench for regfile_wport_arbiter with a tiny regfile model
// that commits every rf_wen write, used to check same-address ordering.
module tb_regfile_wport_arbiter;
    localparam int ASIZE = 4;
    localparam int DSIZE = 16;
    localparam int NREQ  = 3;
    localparam int IDW   = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [DSIZE-1:0] rf_mem [16];

    regfile_wport_arbiter_if #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

    regfile_wport_arbiter #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_wen) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Inputs are already applied; check ready this cycle, then the registered port next cycle.
    task automatic step(input string tag, input logic [NREQ-1:0] exp_ready, input logic exp_wen,
                        input logic [IDW-1:0] exp_gid, input logic [ASIZE-1:0] exp_addr,
                        input logic [DSIZE-1:0] exp_data);
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        chk({tag, "_wen"}, 32'(bus.rf_wen), 32'(exp_wen));
        if (exp_wen) begin
            chk({tag, "_gid"},   32'(bus.grant_id), 32'(exp_gid));
            chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(exp_addr));
            chk({tag, "_wdata"}, 32'(bus.rf_wdata), 32'(exp_data));
        end
    endtask

    initial begin
        logic [NREQ-1:0] exp_oh;
        n_cmp = 0;
        n_err = 0;
        for (int r = 0; r < 16; r++) rf_mem[r] = '0;
        rst           = 1'b1;
        bus.rf_hold   = 1'b0;
        bus.req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*ASIZE +: ASIZE] = ASIZE'(i + 1);
            bus.req_data[i*DSIZE +: DSIZE] = DSIZE'(16'h1000 + i);
        end

        step("rst0", 3'b000, 1'b0, '0, '0, '0);
        step("rst1", 3'b000, 1'b0, '0, '0, '0);
        chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_wdata", 32'(bus.rf_wdata), 32'd0);
        chk("rst_gid",   32'(bus.grant_id), 32'd0);
        rst = 1'b0;

`ifdef WARB_PRIO0_EN
        for (int k = 0; k < 4; k++) begin
            step("prio0", 3'b001, 1'b1, 3'd0, 4'd1, 16'h1000);
        end
        bus.req_valid = 3'b110;
        step("prio_rr1", 3'b010, 1'b1, 3'd1, 4'd2, 16'h1001);
        step("prio_rr2", 3'b100, 1'b1, 3'd2, 4'd3, 16'h1002);
        step("prio_rr3", 3'b010, 1'b1, 3'd1, 4'd2, 16'h1001);
`else
        for (int k = 0; k < 6; k++) begin
            exp_oh = 3'b001 << (k % 3);
            step("rr", exp_oh, 1'b1, IDW'(k % 3), ASIZE'(k % 3 + 1), DSIZE'(16'h1000 + k % 3));
        end
        bus.req_valid = 3'b000;
        step("idle", 3'b000, 1'b0, '0, '0, '0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        bus.req_addr[1*ASIZE +: ASIZE] = 4'd3;
        bus.req_data[1*DSIZE +: DSIZE] = 16'h00A5;
        bus.req_valid = 3'b010;
        #1;
        chk("single_busy", 32'(bus.busy), 32'd0);
        step("single", 3'b010, 1'b1, 3'd1, 4'd3, 16'h00A5);

        // rr_ptr is now 2: both target r5, req2 wins first, req0 lands last.
        bus.req_addr[0*ASIZE +: ASIZE] = 4'd5;
        bus.req_data[0*DSIZE +: DSIZE] = 16'h0001;
        bus.req_addr[2*ASIZE +: ASIZE] = 4'd5;
        bus.req_data[2*DSIZE +: DSIZE] = 16'h0007;
        bus.req_valid = 3'b101;
        step("conf_a", 3'b100, 1'b1, 3'd2, 4'd5, 16'h0007);
        bus.req_valid = 3'b001;
        step("conf_b", 3'b001, 1'b1, 3'd0, 4'd5, 16'h0001);
        bus.req_valid = 3'b000;
        step("conf_idle", 3'b000, 1'b0, '0, '0, '0);
        chk("conf_r5", 32'(rf_mem[5]), 32'h0001);

        bus.rf_hold   = 1'b1;
        bus.req_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            step("hold", 3'b000, 1'b0, '0, '0, '0);
            chk("hold_busy", 32'(bus.busy), 32'd1);
        end
        chk("hold_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("hold_wdata", 32'(bus.rf_wdata), 32'h0001);
        chk("hold_gid",   32'(bus.grant_id), 32'd0);
        bus.rf_hold = 1'b0;
        step("release", 3'b001, 1'b1, 3'd0, 4'd5, 16'h0001);

        bus.req_addr[1*ASIZE +: ASIZE] = 4'd0;
        bus.req_data[1*DSIZE +: DSIZE] = 16'hBEEF;
        bus.req_valid = 3'b010;
        step("r0", 3'b010, 1'b1, 3'd1, 4'd0, 16'hBEEF);

        rst           = 1'b1;
        bus.req_valid = 3'b100;
        step("rst_mid", 3'b000, 1'b0, '0, '0, '0);
        rst           = 1'b0;
        bus.req_valid = 3'b111;
        step("post_rst", 3'b001, 1'b1, 3'd0, 4'd5, 16'h0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
